tile_ram_arbiter: RTL and testbench
===================================

Name: tile_ram_arbiter

Overview:
- Shares one single-port on-chip tile/sprite RAM between two requesters.
  - Render path: color mapper pixel fetch. Absolute priority, fixed latency.
  - Game-logic path: level scrolling and block/score updates. Valid/grant handshake.
- Game-logic writes are held off until vertical blank so the visible frame never tears.
- Sits between the color mapper, the game-state logic and the RAM macro; vblank comes from the VGA timing block.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles, from ram_addr registered to ram_rdata valid. Range 1..3.
- MAX_WAIT, 1024, game-logic wait cycles before gl_starve sets. Range 1..65535.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high.
- vblank  in  1  level, 1 during vertical blanking; synchronous to Clk.
- rnd_req  in  1  render read request; single cycle, never stalled.
- rnd_addr  in  ADDR_W  render read address.
- rnd_data  out  DATA_W  render read data.
- rnd_valid  out  1  rnd_data valid, one cycle.
- gl_req  in  1  game-logic request; held with stable fields until granted.
- gl_we  in  1  1 = write, 0 = read.
- gl_addr  in  ADDR_W  game-logic address.
- gl_wdata  in  DATA_W  game-logic write data.
- gl_gnt  out  1  request accepted this cycle (combinational).
- gl_rdata  out  DATA_W  game-logic read data.
- gl_rvalid  out  1  gl_rdata valid, one cycle.
- gl_starve  out  1  sticky starvation flag.
- ram_addr  out  ADDR_W  to RAM, registered.
- ram_we  out  1  to RAM, registered.
- ram_wdata  out  DATA_W  to RAM, registered.
- ram_rdata  in  DATA_W  from RAM.

Behaviour:

Arbitration, per cycle t:
- gl_gnt = gl_req & ~rnd_req & (~gl_we | vblank) & ~Reset.
- Render slot when rnd_req=1. Game slot when gl_gnt=1. Otherwise idle.
- Simultaneous rnd_req and gl_req: render always wins; gl_gnt=0 and the request remains pending.
- Game writes are never granted while vblank=0, even on idle cycles. Game reads may use any idle cycle.

RAM interface:
- At edge t→t+1: ram_addr/ram_we/ram_wdata take the winning requester's fields.
  - Render slot: ram_we=0.
  - Game slot: ram_we=gl_we.
  - Idle: ram_we=0, ram_addr and ram_wdata hold their previous values.
- A write is performed only on a cycle where ram_we=1.

Read return:
- A tag shift register of depth 1+RD_LAT records per slot {valid, owner=R/G} for reads only. Writes and idle cycles insert an invalid tag.
- A read granted in cycle t returns at cycle t+1+RD_LAT, default t+2.
  - Owner R: rnd_valid=1 and rnd_data=ram_rdata.
  - Owner G: gl_rvalid=1 and gl_rdata=ram_rdata.
- rnd_data and gl_rdata hold their last value when not valid.
- Render reads return in request order with constant latency. Back-to-back rnd_req every cycle gives rnd_valid every cycle.
- Game writes produce no response. A write granted at t is visible to any read granted at t+1 or later.

Starvation:
- A 16-bit wait counter increments on each cycle with gl_req=1 & gl_gnt=0.
- It clears on gl_gnt=1 or gl_req=0, and saturates at MAX_WAIT.
- When the counter reaches MAX_WAIT, gl_starve sets and stays 1 until Reset.

Reset:
- Synchronous. All outputs go to 0: ram_*, rnd_*, gl_rdata, gl_rvalid, gl_gnt, gl_starve.
- Tag pipe and wait counter clear.
- Reads in flight when Reset asserts are dropped; no valid pulses for them after Reset deasserts.
- The first grant is possible in the cycle after Reset deasserts.

vblank edges:
- vblank falling while a game write is pending: the write stays pending, no grant, until the next vblank=1 cycle.
- A write granted on the last vblank cycle completes normally.

Test Plan:
1. Reset, then rnd_req=1 for one cycle with rnd_addr=0x010 (RAM[0x010]=0xA5) → rnd_valid=1 and rnd_data=0xA5 exactly 2 cycles later (RD_LAT=1); gl_rvalid stays 0.
2. rnd_req every cycle for 8 cycles, addresses 0x000–0x007, with gl_req read of 0x100 held throughout → gl_gnt=0 for all 8 cycles; gl_gnt=1 on cycle 9; gl_rvalid and RAM[0x100] returned 2 cycles after that; render data arrives in order, contiguous.
3. vblank=0, gl_req write 0x200←0x3C, no render traffic → no gl_gnt and ram_we never 1. Raise vblank → gl_gnt the same cycle, ram_we=1 next cycle. A following gl read of 0x200 returns 0x3C.
4. MAX_WAIT=16, vblank=0, gl write pending for 20 cycles → gl_starve rises on wait count 16, stays 1 after vblank grants the write, and clears only on Reset.
5. Issue render read at t and game read at t+1, assert Reset at t+1 for one cycle → no rnd_valid or gl_rvalid afterwards, all outputs 0 after the reset edge, and a new render read succeeds with 2-cycle latency.
6. RD_LAT=3 build: alternating render and game reads on idle-free cycles → each valid arrives exactly 4 cycles after its grant, routed to the correct owner with no cross-delivery.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// Shares one single-port tile RAM: render reads win every conflict, game-logic writes wait for vblank.
// Read data returns 1+RD_LAT cycles after grant; render never stalls, game side holds gl_req until gl_gnt.
module tile_ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vblank,
    input  logic              rnd_req,
    input  logic [ADDR_W-1:0] rnd_addr,
    output logic [DATA_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic [DATA_W-1:0] gl_rdata,
    output logic              gl_rvalid,
    output logic              gl_starve,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [15:0] WAIT_MAX = 16'(MAX_WAIT);

    logic [RD_LAT:0]   tag_vld;
    logic [RD_LAT:0]   tag_gl;
    logic [15:0]       wait_cnt;
    logic [DATA_W-1:0] rnd_data_q;
    logic [DATA_W-1:0] gl_rdata_q;
    logic              slot_rd;
    logic              wait_inc;

    assign gl_gnt   = gl_req & ~rnd_req & (~gl_we | vblank) & ~Reset;
    assign slot_rd  = rnd_req | (gl_gnt & ~gl_we);
    assign wait_inc = gl_req & ~gl_gnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (rnd_req) begin
            ram_addr <= rnd_addr;
            ram_we   <= 1'b0;
        end else if (gl_gnt) begin
            ram_addr  <= gl_addr;
            ram_we    <= gl_we;
            ram_wdata <= gl_wdata;
        end else begin
            ram_we <= 1'b0;
        end
    end

    // One tag per slot; the oldest stage lines up with ram_rdata for that slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tag_vld <= '0;
            tag_gl  <= '0;
        end else begin
            tag_vld <= {tag_vld[RD_LAT-1:0], slot_rd};
            tag_gl  <= {tag_gl[RD_LAT-1:0], ~rnd_req};
        end
    end

    assign rnd_valid = tag_vld[RD_LAT] & ~tag_gl[RD_LAT] & ~Reset;
    assign gl_rvalid = tag_vld[RD_LAT] &  tag_gl[RD_LAT] & ~Reset;
    assign rnd_data  = rnd_valid ? ram_rdata : rnd_data_q;
    assign gl_rdata  = gl_rvalid ? ram_rdata : gl_rdata_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rnd_data_q <= '0;
            gl_rdata_q <= '0;
        end else begin
            if (rnd_valid) rnd_data_q <= ram_rdata;
            if (gl_rvalid) gl_rdata_q <= ram_rdata;
        end
    end

    // Flag is raised on the same edge the counter lands on WAIT_MAX.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt  <= '0;
            gl_starve <= 1'b0;
        end else if (!wait_inc) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt + 16'd1 == WAIT_MAX) gl_starve <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench: one RD_LAT=1/MAX_WAIT=16 instance and one RD_LAT=3 instance, each with a behavioural RAM.
module tb_tile_ram_arbiter;

    logic Clk = 1'b0;
    always #10 Clk = ~Clk;

    logic        Reset, vblank, rnd_req, gl_req, gl_we;
    logic [11:0] rnd_addr, gl_addr, ram_addr;
    logic [7:0]  gl_wdata, rnd_data, gl_rdata, ram_wdata, ram_rdata;
    logic        rnd_valid, gl_gnt, gl_rvalid, gl_starve, ram_we;

    logic        vblank3, rnd_req3, gl_req3, gl_we3;
    logic [11:0] rnd_addr3, gl_addr3, ram_addr3;
    logic [7:0]  gl_wdata3, rnd_data3, gl_rdata3, ram_wdata3, ram_rdata3;
    logic        rnd_valid3, gl_gnt3, gl_rvalid3, gl_starve3, ram_we3;

    int n_chk  = 0;
    int n_fail = 0;

    tile_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(1), .MAX_WAIT(16)) dut (
        .Clk(Clk), .Reset(Reset), .vblank(vblank),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_gnt(gl_gnt), .gl_rdata(gl_rdata), .gl_rvalid(gl_rvalid), .gl_starve(gl_starve),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    tile_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(3), .MAX_WAIT(1024)) dut3 (
        .Clk(Clk), .Reset(Reset), .vblank(vblank3),
        .rnd_req(rnd_req3), .rnd_addr(rnd_addr3), .rnd_data(rnd_data3), .rnd_valid(rnd_valid3),
        .gl_req(gl_req3), .gl_we(gl_we3), .gl_addr(gl_addr3), .gl_wdata(gl_wdata3),
        .gl_gnt(gl_gnt3), .gl_rdata(gl_rdata3), .gl_rvalid(gl_rvalid3), .gl_starve(gl_starve3),
        .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    // Power-on RAM contents: RAM[0x010] = 0xA5, RAM[0x100] = 0x35, RAM[0x200] = 0x35.
    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] * 8'd7 + 8'h35;
    endfunction

    logic [7:0] mem1 [4096];
    bit         wr1  [4096];
    logic [7:0] rd1;
    always @(posedge Clk) begin
        rd1 <= wr1[ram_addr] ? mem1[ram_addr] : pat(ram_addr);
        if (ram_we) begin
            mem1[ram_addr] <= ram_wdata;
            wr1[ram_addr]  <= 1'b1;
        end
    end
    assign ram_rdata = rd1;

    logic [7:0] p3 [3];
    always @(posedge Clk) begin
        p3[0] <= pat(ram_addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata3 = p3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; vblank = 1'b0; rnd_req = 1'b0; rnd_addr = '0;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 12'h100; gl_wdata = '0;
        vblank3 = 1'b0; rnd_req3 = 1'b0; rnd_addr3 = '0;
        gl_req3 = 1'b0; gl_we3 = 1'b0; gl_addr3 = '0; gl_wdata3 = '0;
        step();
        step();
        @(negedge Clk);
        check("rst gl_gnt", gl_gnt, 0);
        check("rst rnd_valid", rnd_valid, 0);
        check("rst rnd_data", rnd_data, 0);
        check("rst gl_rvalid", gl_rvalid, 0);
        check("rst gl_rdata", gl_rdata, 0);
        check("rst gl_starve", gl_starve, 0);
        check("rst ram_addr", ram_addr, 0);
        check("rst ram_we", ram_we, 0);
        check("rst ram_wdata", ram_wdata, 0);
        step();
        Reset = 1'b0; gl_req = 1'b0;

        // Single render read, two-cycle latency.
        for (int c = 0; c < 4; c++) begin
            rnd_req = (c == 0); rnd_addr = 12'h010;
            @(negedge Clk);
            check("t1 rnd_valid", rnd_valid, (c == 2));
            check("t1 gl_rvalid", gl_rvalid, 0);
            if (c >= 2) check("t1 rnd_data", rnd_data, 8'hA5);
            step();
        end

        // Render burst blocks a pending game read until the burst ends.
        for (int c = 0; c < 12; c++) begin
            rnd_req = (c < 8); rnd_addr = 12'(c);
            gl_req = (c <= 8); gl_we = 1'b0; gl_addr = 12'h100;
            @(negedge Clk);
            check("t2 gl_gnt", gl_gnt, (c == 8));
            check("t2 rnd_valid", rnd_valid, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) check("t2 rnd_data", rnd_data, pat(12'(c - 2)));
            check("t2 gl_rvalid", gl_rvalid, (c == 10));
            if (c == 10) check("t2 gl_rdata", gl_rdata, 8'h35);
            step();
        end

        // Write held off until vblank, then read back.
        for (int c = 0; c < 9; c++) begin
            rnd_req = 1'b0;
            vblank = (c == 5);
            gl_req = (c <= 6); gl_we = (c <= 5); gl_addr = 12'h200; gl_wdata = 8'h3C;
            @(negedge Clk);
            check("t3 gl_gnt", gl_gnt, (c == 5 || c == 6));
            check("t3 ram_we", ram_we, (c == 6));
            if (c == 6) begin
                check("t3 ram_addr", ram_addr, 12'h200);
                check("t3 ram_wdata", ram_wdata, 8'h3C);
            end
            check("t3 gl_rvalid", gl_rvalid, (c == 8));
            if (c == 8) check("t3 gl_rdata", gl_rdata, 8'h3C);
            step();
        end

        // Starvation flag after 16 waiting cycles, sticky through the grant.
        for (int c = 0; c < 24; c++) begin
            vblank = (c == 20);
            gl_req = (c <= 20); gl_we = 1'b1; gl_addr = 12'h300; gl_wdata = 8'h77;
            @(negedge Clk);
            check("t4 gl_starve", gl_starve, (c >= 16));
            check("t4 gl_gnt", gl_gnt, (c == 20));
            check("t4 ram_we", ram_we, (c == 21));
            step();
        end
        Reset = 1'b1;
        step();
        @(negedge Clk);
        check("t4 starve after reset", gl_starve, 0);
        step();
        Reset = 1'b0;

        // Load nonzero return registers, then reset with reads in flight.
        for (int c = 0; c < 4; c++) begin
            rnd_req = (c == 0); rnd_addr = 12'h010;
            gl_req = (c == 1); gl_we = 1'b0; gl_addr = 12'h100;
            @(negedge Clk);
            if (c == 2) check("t5 pre rnd_data", rnd_data, 8'hA5);
            if (c == 3) check("t5 pre gl_rdata", gl_rdata, 8'h35);
            step();
        end
        for (int c = 0; c < 7; c++) begin
            rnd_req = (c == 0 || c == 4); rnd_addr = (c == 0) ? 12'h005 : 12'h003;
            gl_req = (c == 1); gl_we = 1'b0; gl_addr = 12'h100;
            Reset = (c == 1);
            @(negedge Clk);
            check("t5 gl_gnt", gl_gnt, 0);
            check("t5 rnd_valid", rnd_valid, (c == 6));
            check("t5 gl_rvalid", gl_rvalid, 0);
            if (c == 2) begin
                check("t5 rnd_data", rnd_data, 0);
                check("t5 gl_rdata", gl_rdata, 0);
                check("t5 ram_addr", ram_addr, 0);
                check("t5 ram_we", ram_we, 0);
                check("t5 gl_starve", gl_starve, 0);
            end
            if (c == 6) check("t5 new rnd_data", rnd_data, 8'h4A);
            step();
        end
        Reset = 1'b0;

        // RD_LAT=3: alternating owners, each return 4 cycles after grant.
        for (int c = 0; c < 12; c++) begin
            rnd_req3 = (c < 6 && c % 2 == 0); rnd_addr3 = 12'(12'h020 + c);
            gl_req3 = (c < 6 && c % 2 == 1); gl_we3 = 1'b0; gl_addr3 = 12'(12'h040 + c);
            @(negedge Clk);
            check("t6 gl_gnt", gl_gnt3, (c < 6 && c % 2 == 1));
            check("t6 rnd_valid", rnd_valid3, (c >= 4 && c < 10 && c % 2 == 0));
            check("t6 gl_rvalid", gl_rvalid3, (c >= 4 && c < 10 && c % 2 == 1));
            if (c >= 4 && c < 10 && c % 2 == 0) check("t6 rnd_data", rnd_data3, pat(12'(12'h020 + c - 4)));
            if (c >= 4 && c < 10 && c % 2 == 1) check("t6 gl_rdata", gl_rdata3, pat(12'(12'h040 + c - 4)));
            if (c == 2) check("t6 ram_we", ram_we3, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
